mmio_axi_master: RTL and testbench

MMIO_AXI_MASTER -- requirements
Module: mmio_axi_master

---
 rtl/mmio_axi_pkg.sv | 22 ++
 rtl/mmio_axi_master.sv | 168 ++++++++++++++++
 tb/tb_mmio_axi_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_axi_pkg.sv
// Shared types and constants for the MMIO-to-AXI4-Lite master bridge:
// FSM state encoding, AXI response codes and default parameter values.
package mmio_axi_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 1024;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_AW_W = 3'd1,
      WR_B    = 3'd2,
      RD_AR   = 3'd3,
      RD_R    = 3'd4,
      RESP    = 3'd5
   } state_t;

endpackage

// File: rtl/mmio_axi_master.sv
// Single-outstanding MMIO request port bridged onto an AXI4-Lite master,
// with a sticky timeout flag raised when a slave response is slow.
module mmio_axi_master
   import mmio_axi_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                aclk,
   input  logic                arst,

   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,

   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,

   output logic [ADDR_W-1:0]   M_AXI_awaddr,
   output logic [2:0]          M_AXI_awprot,
   output logic                M_AXI_awvalid,
   input  logic                M_AXI_awready,
   output logic [DATA_W-1:0]   M_AXI_wdata,
   output logic [DATA_W/8-1:0] M_AXI_wstrb,
   output logic                M_AXI_wvalid,
   input  logic                M_AXI_wready,
   input  logic [1:0]          M_AXI_bresp,
   input  logic                M_AXI_bvalid,
   output logic                M_AXI_bready,
   output logic [ADDR_W-1:0]   M_AXI_araddr,
   output logic [2:0]          M_AXI_arprot,
   output logic                M_AXI_arvalid,
   input  logic                M_AXI_arready,
   input  logic [DATA_W-1:0]   M_AXI_rdata,
   input  logic [1:0]          M_AXI_rresp,
   input  logic                M_AXI_rvalid,
   output logic                M_AXI_rready,

   output logic                timeout_flag,
   output logic [2:0]          debug_state
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic                aw_done, w_done;
   logic [CNT_W-1:0]    wait_cnt;

   logic accept, misaligned, aw_hs, w_hs, in_wait;

   assign accept     = req_valid & req_ready;
   assign misaligned = (req_addr[1:0] != 2'b00);
   assign aw_hs      = M_AXI_awvalid & M_AXI_awready;
   assign w_hs       = M_AXI_wvalid & M_AXI_wready;
   assign in_wait    = state_q inside {WR_AW_W, WR_B, RD_AR, RD_R};

   assign M_AXI_awaddr = addr_q;
   assign M_AXI_araddr = addr_q;
   assign M_AXI_wdata  = wdata_q;
   assign M_AXI_wstrb  = wstrb_q;
   assign M_AXI_awprot = 3'b000;
   assign M_AXI_arprot = 3'b000;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (misaligned)  state_d = RESP;
               else if (req_we) state_d = WR_AW_W;
               else             state_d = RD_AR;
            end
         end
         // AW and W complete independently; leave once both have been seen.
         WR_AW_W: if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = WR_B;
         WR_B:    if (M_AXI_bvalid)  state_d = RESP;
         RD_AR:   if (M_AXI_arready) state_d = RD_R;
         RD_R:    if (M_AXI_rvalid)  state_d = RESP;
         RESP:    if (rsp_ready)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = (state_q == IDLE) & ~arst;
      M_AXI_awvalid = (state_q == WR_AW_W) & ~aw_done;
      M_AXI_wvalid  = (state_q == WR_AW_W) & ~w_done;
      M_AXI_bready  = (state_q == WR_B);
      M_AXI_arvalid = (state_q == RD_AR);
      M_AXI_rready  = (state_q == RD_R);
      rsp_valid     = (state_q == RESP);
      debug_state   = state_q;
   end

   // Request capture and response latching
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  wstrb_q   <= req_wstrb;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= misaligned;
               end
            end
            WR_AW_W: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            WR_B: begin
               if (M_AXI_bvalid) begin
                  rsp_rdata <= '0;
                  rsp_err   <= (M_AXI_bresp != RESP_OKAY);
               end
            end
            RD_R: begin
               if (M_AXI_rvalid) begin
                  rsp_rdata <= M_AXI_rdata;
                  rsp_err   <= (M_AXI_rresp != RESP_OKAY);
               end
            end
            default: ;
         endcase
      end
   end

   // Response-wait counter; saturates so the flag can never be missed or re-armed
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (in_wait && (wait_cnt != CNT_MAX)) begin
         wait_cnt <= wait_cnt + CNT_ONE;
         if (wait_cnt == (CNT_MAX - CNT_ONE)) timeout_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mmio_axi_master.sv
// Directed bench for mmio_axi_master: a latency-programmable AXI-Lite slave,
// a table of single transactions, and hand-written timeout/backpressure/reset cases.
module tb_mmio_axi_master;
   import mmio_axi_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic aclk = 1'b0;
   logic arst = 1'b1;

   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [3:0]    req_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   logic [AW-1:0] M_AXI_awaddr, M_AXI_araddr;
   logic [2:0]    M_AXI_awprot, M_AXI_arprot;
   logic          M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready;
   logic [DW-1:0] M_AXI_wdata;
   logic [3:0]    M_AXI_wstrb;
   logic          M_AXI_awready = 1'b0;
   logic          M_AXI_wready  = 1'b0;
   logic          M_AXI_bvalid  = 1'b0;
   logic [1:0]    M_AXI_bresp   = 2'b00;
   logic          M_AXI_arready = 1'b0;
   logic          M_AXI_rvalid  = 1'b0;
   logic [1:0]    M_AXI_rresp   = 2'b00;
   logic [DW-1:0] M_AXI_rdata   = '0;
   logic          timeout_flag;
   logic [2:0]    debug_state;

   mmio_axi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .aclk(aclk), .arst(arst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot),
      .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
      .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
      .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
      .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
      .M_AXI_araddr(M_AXI_araddr), .M_AXI_arprot(M_AXI_arprot),
      .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
      .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
      .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
      .timeout_flag(timeout_flag), .debug_state(debug_state)
   );

   always #5 aclk = ~aclk;

   // Slave model: each ready/valid rises after a programmed number of cycles
   int         cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0, cfg_ar_lat = 0, cfg_r_lat = 0;
   logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = '0;
   int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;

   always @(negedge aclk) begin
      if (M_AXI_awvalid) begin M_AXI_awready = (aw_c >= cfg_aw_lat); aw_c++; end
      else begin M_AXI_awready = 1'b0; aw_c = 0; end
      if (M_AXI_wvalid) begin M_AXI_wready = (w_c >= cfg_w_lat); w_c++; end
      else begin M_AXI_wready = 1'b0; w_c = 0; end
      if (M_AXI_arvalid) begin M_AXI_arready = (ar_c >= cfg_ar_lat); ar_c++; end
      else begin M_AXI_arready = 1'b0; ar_c = 0; end
      if (M_AXI_bready) begin M_AXI_bvalid = (b_c >= cfg_b_lat); M_AXI_bresp = cfg_bresp; b_c++; end
      else begin M_AXI_bvalid = 1'b0; b_c = 0; end
      if (M_AXI_rready) begin
         M_AXI_rvalid = (r_c >= cfg_r_lat); M_AXI_rresp = cfg_rresp; M_AXI_rdata = cfg_rdata; r_c++;
      end else begin M_AXI_rvalid = 1'b0; r_c = 0; end
   end

   // Handshake monitor, sampled on the active edge before the DUT updates
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_wonly = 0, n_arv = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0]  cap_wstrb = '0;

   always @(posedge aclk) begin
      if (M_AXI_awvalid && M_AXI_awready) begin n_aw++; cap_awaddr = M_AXI_awaddr; end
      if (M_AXI_wvalid && M_AXI_wready) begin n_w++; cap_wdata = M_AXI_wdata; cap_wstrb = M_AXI_wstrb; end
      if (M_AXI_bvalid && M_AXI_bready) n_b++;
      if (M_AXI_arvalid && M_AXI_arready) begin n_ar++; cap_araddr = M_AXI_araddr; end
      if (M_AXI_rvalid && M_AXI_rready) n_r++;
      if (M_AXI_wvalid && !M_AXI_awvalid) n_wonly++;
      if (M_AXI_arvalid) n_arv++;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_axi;
      int          exp_wonly;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input int idx);
      int naw0, nw0, nb0, nar0, nr0, nwo0, narv0, lat;
      bit got;
      naw0 = n_aw; nw0 = n_w; nb0 = n_b; nar0 = n_ar; nr0 = n_r; nwo0 = n_wonly; narv0 = n_arv;
      cfg_aw_lat = v.aw_lat; cfg_w_lat = v.w_lat; cfg_b_lat = v.b_lat;
      cfg_ar_lat = v.ar_lat; cfg_r_lat = v.r_lat;
      cfg_bresp = v.resp; cfg_rresp = v.resp; cfg_rdata = v.rdata;
      @(negedge aclk);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
      chk($sformatf("v%0d req_ready", idx), req_ready, 1);
      @(negedge aclk);
      req_valid = 1'b0;
      lat = 1; got = 0;
      for (int c = 0; c < 200; c++) begin
         if (rsp_valid) begin got = 1; break; end
         @(negedge aclk);
         lat++;
      end
      chk($sformatf("v%0d rsp_valid seen", idx), got, 1);
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
      chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d timeout_flag", idx), timeout_flag, 0);
      if (v.exp_axi == 0) begin
         chk($sformatf("v%0d no AW/W/AR", idx), (n_aw - naw0) + (n_w - nw0) + (n_ar - nar0), 0);
         chk($sformatf("v%0d arvalid cycles", idx), n_arv - narv0, 0);
      end else if (v.we) begin
         chk($sformatf("v%0d AW count", idx), n_aw - naw0, 1);
         chk($sformatf("v%0d W count", idx), n_w - nw0, 1);
         chk($sformatf("v%0d B count", idx), n_b - nb0, 1);
         chk($sformatf("v%0d AR count", idx), n_ar - nar0, 0);
         chk($sformatf("v%0d awaddr", idx), cap_awaddr, v.addr);
         chk($sformatf("v%0d wdata", idx), cap_wdata, v.wdata);
         chk($sformatf("v%0d wstrb", idx), cap_wstrb, v.wstrb);
         chk($sformatf("v%0d W-only cycles", idx), n_wonly - nwo0, v.exp_wonly);
      end else begin
         chk($sformatf("v%0d AR count", idx), n_ar - nar0, 1);
         chk($sformatf("v%0d R count", idx), n_r - nr0, 1);
         chk($sformatf("v%0d AW count", idx), n_aw - naw0, 0);
         chk($sformatf("v%0d araddr", idx), cap_araddr, v.addr);
      end
      @(negedge aclk);
      chk($sformatf("v%0d back to IDLE", idx), {rsp_valid, debug_state}, {1'b0, IDLE});
   endtask

   initial begin
      int lat, naw0, nr0;
      bit got;
      logic [31:0] held;

      //          we    addr          wdata         strb  aw w  b  ar r  resp   rdata         err   exp_rdata     lat axi wonly
      vecs[0] = '{1'b1, 32'h4600_0100, 32'h0000_000F, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b0, 32'h0,        3, 1, 0};
      vecs[1] = '{1'b0, 32'h4600_0104, 32'h0,         4'h0, 0, 0, 0, 0, 4, 2'b00, 32'h0000_01FF, 1'b0, 32'h0000_01FF, 7, 1, 0};
      vecs[2] = '{1'b1, 32'h4600_0108, 32'hCAFE_0001, 4'hF, 0, 2, 0, 0, 0, 2'b00, 32'h0,        1'b0, 32'h0,        5, 1, 2};
      vecs[3] = '{1'b0, 32'h4600_0110, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 3, 1, 0};
      vecs[4] = '{1'b0, 32'h4600_0102, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_0000, 1'b1, 32'h0,        1, 0, 0};
      vecs[5] = '{1'b1, 32'h4600_0200, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 2'b11, 32'h0,        1'b1, 32'h0,        6, 1, 0};
      vecs[6] = '{1'b1, 32'h4600_0101, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b1, 32'h0,        1, 0, 0};
      vecs[7] = '{1'b1, 32'h4600_0300, 32'hFFFF_0000, 4'hC, 1, 1, 2, 0, 0, 2'b10, 32'h0,        1'b1, 32'h0,        6, 1, 0};

      // Reset state
      @(negedge aclk);
      @(negedge aclk);
      chk("reset req_ready", req_ready, 0);
      chk("reset valids/readies",
          {rsp_valid, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready}, 0);
      chk("reset addr/data", {M_AXI_awaddr, M_AXI_wdata}, 0);
      chk("reset strb/prot", {M_AXI_wstrb, M_AXI_awprot, M_AXI_arprot}, 0);
      chk("reset rsp", {rsp_err, rsp_rdata}, 0);
      chk("reset state/flag", {timeout_flag, debug_state}, {1'b0, IDLE});
      arst = 1'b0;
      #1;
      chk("post-reset req_ready", req_ready, 1);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Timeout: B withheld 20 cycles with TIMEOUT=8
      cfg_aw_lat = 0; cfg_w_lat = 0; cfg_b_lat = 20; cfg_bresp = 2'b10;
      @(negedge aclk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4600_0400; req_wdata = 32'h0BAD_F00D; req_wstrb = 4'hF;
      @(negedge aclk);
      req_valid = 1'b0;
      lat = 1; got = 0;
      for (int c = 0; c < 60; c++) begin
         if (lat == 8) chk("timeout flag before", timeout_flag, 0);
         if (lat == 9) chk("timeout flag at limit", timeout_flag, 1);
         if (rsp_valid) begin got = 1; break; end
         @(negedge aclk);
         lat++;
      end
      chk("timeout rsp seen", got, 1);
      chk("timeout latency", lat, 23);
      chk("timeout rsp_err", rsp_err, 1);
      chk("timeout flag at rsp", timeout_flag, 1);
      @(negedge aclk);
      chk("timeout flag sticky", {timeout_flag, debug_state}, {1'b1, IDLE});
      arst = 1'b1;
      #1;
      chk("timeout flag cleared by reset", timeout_flag, 0);
      @(negedge aclk);
      arst = 1'b0;

      // Response backpressure: rsp_ready low for 5 cycles while a new request waits
      cfg_ar_lat = 0; cfg_r_lat = 0; cfg_rresp = 2'b00; cfg_rdata = 32'hA5A5_0001;
      rsp_ready = 1'b0;
      @(negedge aclk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4600_0500;
      @(negedge aclk);
      req_we = 1'b1; req_addr = 32'h4600_0504;
      naw0 = n_aw;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid) begin got = 1; break; end
         @(negedge aclk);
      end
      chk("bp rsp seen", got, 1);
      held = rsp_rdata;
      chk("bp rdata", held, 32'hA5A5_0001);
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         chk($sformatf("bp hold c%0d", k), {rsp_valid, req_ready, rsp_rdata, rsp_err}, {1'b1, 1'b0, held, 1'b0});
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge aclk);
      chk("bp released", {rsp_valid, debug_state}, {1'b0, IDLE});
      chk("bp pending req not taken", n_aw - naw0, 0);

      // Reset in the middle of RD_R
      cfg_r_lat = 50;
      nr0 = n_r;
      @(negedge aclk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4600_0600;
      @(negedge aclk);
      req_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (debug_state == RD_R) begin got = 1; break; end
         @(negedge aclk);
      end
      chk("rst reached RD_R", got, 1);
      chk("rst rready before", M_AXI_rready, 1);
      @(negedge aclk);
      arst = 1'b1;
      #1;
      chk("rst drops valids", {M_AXI_arvalid, M_AXI_rready, rsp_valid}, 0);
      chk("rst state", {req_ready, debug_state}, {1'b0, IDLE});
      chk("rst rsp cleared", {rsp_err, rsp_rdata}, 0);
      @(negedge aclk);
      arst = 1'b0;
      #1;
      chk("rst req_ready after", req_ready, 1);
      got = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge aclk);
         if (rsp_valid) got = 1;
      end
      chk("rst no response", got, 0);
      chk("rst no R beat", n_r - nr0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
